// File: rtl/keypad_pkg.sv
// Shared definitions for the 3x4 keypad cursor controller:
// grid size, key codes, repeat-FSM states and grid helpers.
package keypad_pkg;

    localparam int GRID_COLS = 3;
    localparam int GRID_ROWS = 4;

    localparam logic [3:0] COL_MAX = 4'(GRID_COLS - 1);
    localparam logic [3:0] ROW_MAX = 4'(GRID_ROWS - 1);

    localparam logic [3:0] KEY_STAR = 4'hA;
    localparam logic [3:0] KEY_ZERO = 4'h0;
    localparam logic [3:0] KEY_HASH = 4'hB;

    // Button slots; the four directions use 0..3 so a dir_t
    // value can index the accepted-level vector directly.
    localparam int BTN_UP    = 0;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_LEFT  = 2;
    localparam int BTN_RIGHT = 3;
    localparam int BTN_OK    = 4;
    localparam int BTN_NUM   = 5;

    typedef enum logic [1:0] {
        RPT_IDLE,
        RPT_HOLD,
        RPT_REPEAT
    } rpt_state_t;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    function automatic logic [3:0] wrap_inc(
        input logic [3:0] v,
        input logic [3:0] vmax
    );
        return (v >= vmax) ? 4'd0 : v + 4'd1;
    endfunction

    function automatic logic [3:0] wrap_dec(
        input logic [3:0] v,
        input logic [3:0] vmax
    );
        return (v == 4'd0) ? vmax : v - 4'd1;
    endfunction

    // Rows 0..2 hold digits 1..9; the bottom row is * 0 #.
    function automatic logic [3:0] key_of(
        input logic [3:0] x,
        input logic [3:0] y
    );
        logic [3:0] code;
        code = KEY_ZERO;
        if (y == ROW_MAX) begin
            case (x)
                4'd0:    code = KEY_STAR;
                4'd1:    code = KEY_ZERO;
                default: code = KEY_HASH;
            endcase
        end else begin
            code = y * 4'd3 + x + 4'd1;
        end
        return code;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Debounce filter with press-edge detect for one button.
// Ports: i_clk, i_rst (async high), i_raw (synchronised level),
//        o_level (accepted state), o_press (1-cycle 0->1 pulse).
module btn_debounce #(
    parameter int DEBOUNCE_CYC = 500000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_raw,
    output logic o_level,
    output logic o_press
);

    localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

    logic          r_level;
    logic          r_press;
    logic [CW-1:0] r_cnt;

    // The count runs only while raw disagrees with the accepted
    // level; the press pulse is raised on the same edge that the
    // level flips to 1, so it lines up with the new level.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_level <= 1'b0;
            r_press <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_press <= 1'b0;
            if (i_raw == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_level <= i_raw;
                r_press <= i_raw;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_level = r_level;
    assign o_press = r_press;

endmodule

// File: rtl/cursor_ctrl.sv
// 3x4 keypad cursor controller: debounced buttons move a cursor
// with auto-repeat; OK emits the selected key over valid/ready.
// Ports: clk_in, sys_rst (async high), btn_* raw levels,
//        cursor_x/cursor_y, key_valid/key_code/key_ready, key_ovf.
module cursor_ctrl
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 500000,
    parameter int REPEAT_DLY   = 25000000,
    parameter int REPEAT_PER   = 10000000
) (
    input  logic       clk_in,
    input  logic       sys_rst,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_ok,
    output logic [3:0] cursor_x,
    output logic [3:0] cursor_y,
    output logic       key_valid,
    output logic [3:0] key_code,
    input  logic       key_ready,
    output logic       key_ovf
);

    localparam int TMAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY
                                                    : REPEAT_PER;
    localparam int TW = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam logic [TW-1:0] DLY_LAST = TW'(REPEAT_DLY - 1);
    localparam logic [TW-1:0] PER_LAST = TW'(REPEAT_PER - 1);

    logic [BTN_NUM-1:0] w_raw;
    logic [BTN_NUM-1:0] w_lvl;
    logic [BTN_NUM-1:0] w_prs;

    logic       w_ev_ok;
    logic       w_ev_dir_vld;
    logic       w_ev_any;
    dir_t       w_ev_dir;

    rpt_state_t r_state;
    rpt_state_t w_nxt_state;
    dir_t       r_dir;
    dir_t       w_nxt_dir;
    logic [TW-1:0] r_tmr;
    logic       w_held;
    logic       w_rpt_fire;
    logic       w_mv_vld;
    dir_t       w_mv_dir;

    logic [3:0] r_cur_x;
    logic [3:0] r_cur_y;
    logic       r_key_valid;
    logic [3:0] r_key_code;
    logic       r_key_ovf;

    assign w_raw[BTN_UP]    = btn_up;
    assign w_raw[BTN_DOWN]  = btn_down;
    assign w_raw[BTN_LEFT]  = btn_left;
    assign w_raw[BTN_RIGHT] = btn_right;
    assign w_raw[BTN_OK]    = btn_ok;

    for (genvar g = 0; g < BTN_NUM; g++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYC(DEBOUNCE_CYC)
        ) u_db (
            .i_clk  (clk_in),
            .i_rst  (sys_rst),
            .i_raw  (w_raw[g]),
            .o_level(w_lvl[g]),
            .o_press(w_prs[g])
        );
    end

    // Event arbitration: OK beats every direction; among the
    // directions the first listed wins, the rest are dropped.
    assign w_ev_ok      = w_prs[BTN_OK];
    assign w_ev_dir_vld = !w_ev_ok && (|w_prs[BTN_RIGHT:BTN_UP]);
    assign w_ev_any     = |w_prs;

    always_comb begin
        w_ev_dir = DIR_UP;
        priority case (1'b1)
            w_prs[BTN_UP]:    w_ev_dir = DIR_UP;
            w_prs[BTN_DOWN]:  w_ev_dir = DIR_DOWN;
            w_prs[BTN_LEFT]:  w_ev_dir = DIR_LEFT;
            w_prs[BTN_RIGHT]: w_ev_dir = DIR_RIGHT;
            default:          w_ev_dir = DIR_UP;
        endcase
    end

    // Accepted level of the direction currently being held.
    assign w_held = w_lvl[{1'b0, r_dir}];

    always_ff @(posedge clk_in or posedge sys_rst) begin
        if (sys_rst) begin
            r_state <= RPT_IDLE;
            r_dir   <= DIR_UP;
        end else begin
            r_state <= w_nxt_state;
            r_dir   <= w_nxt_dir;
        end
    end

    // A fresh direction press restarts HOLD on that direction;
    // an OK press or a release of the held button ends repeat.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_dir   = r_dir;
        if (w_ev_ok) begin
            w_nxt_state = RPT_IDLE;
        end else if (w_ev_dir_vld) begin
            w_nxt_state = RPT_HOLD;
            w_nxt_dir   = w_ev_dir;
        end else begin
            unique case (r_state)
                RPT_HOLD: begin
                    if (!w_held) begin
                        w_nxt_state = RPT_IDLE;
                    end else if (r_tmr == DLY_LAST) begin
                        w_nxt_state = RPT_REPEAT;
                    end
                end
                RPT_REPEAT: begin
                    if (!w_held) begin
                        w_nxt_state = RPT_IDLE;
                    end
                end
                default: begin
                    w_nxt_state = RPT_IDLE;
                end
            endcase
        end
    end

    // Timer counts cycles spent in the current state and wraps
    // at the repeat period while repeating.
    always_ff @(posedge clk_in or posedge sys_rst) begin
        if (sys_rst) begin
            r_tmr <= '0;
        end else if (w_ev_any || (r_state != w_nxt_state)
                     || (r_state == RPT_IDLE)) begin
            r_tmr <= '0;
        end else if ((r_state == RPT_REPEAT) && (r_tmr == PER_LAST)) begin
            r_tmr <= '0;
        end else begin
            r_tmr <= r_tmr + 1'b1;
        end
    end

    always_comb begin
        w_rpt_fire = 1'b0;
        if (w_held && !w_ev_any) begin
            unique case (r_state)
                RPT_HOLD:   w_rpt_fire = (r_tmr == DLY_LAST);
                RPT_REPEAT: w_rpt_fire = (r_tmr == PER_LAST);
                default:    w_rpt_fire = 1'b0;
            endcase
        end
        w_mv_vld = w_ev_dir_vld || w_rpt_fire;
        w_mv_dir = w_ev_dir_vld ? w_ev_dir : r_dir;
    end

    always_ff @(posedge clk_in or posedge sys_rst) begin
        if (sys_rst) begin
            r_cur_x <= 4'd0;
            r_cur_y <= 4'd0;
        end else if (w_mv_vld) begin
            unique case (w_mv_dir)
                DIR_UP:    r_cur_y <= wrap_dec(r_cur_y, ROW_MAX);
                DIR_DOWN:  r_cur_y <= wrap_inc(r_cur_y, ROW_MAX);
                DIR_LEFT:  r_cur_x <= wrap_dec(r_cur_x, COL_MAX);
                DIR_RIGHT: r_cur_x <= wrap_inc(r_cur_x, COL_MAX);
                default:   r_cur_x <= r_cur_x;
            endcase
        end
    end

    // Key slot: a press may load when the slot is empty or being
    // drained this cycle; otherwise it is dropped and flagged.
    always_ff @(posedge clk_in or posedge sys_rst) begin
        if (sys_rst) begin
            r_key_valid <= 1'b0;
            r_key_code  <= 4'd0;
            r_key_ovf   <= 1'b0;
        end else begin
            r_key_ovf <= 1'b0;
            if (w_ev_ok) begin
                if (!r_key_valid || key_ready) begin
                    r_key_valid <= 1'b1;
                    r_key_code  <= key_of(r_cur_x, r_cur_y);
                end else begin
                    r_key_ovf <= 1'b1;
                end
            end else if (r_key_valid && key_ready) begin
                r_key_valid <= 1'b0;
            end
        end
    end

    assign cursor_x  = r_cur_x;
    assign cursor_y  = r_cur_y;
    assign key_valid = r_key_valid;
    assign key_code  = r_key_code;
    assign key_ovf   = r_key_ovf;

endmodule

// File: tb/tb_cursor_ctrl.sv
// Scoreboard bench for cursor_ctrl with short debounce/repeat
// timing; expected moves and keys are queued as stimulus is driven.
module tb_cursor_ctrl;

    localparam int M_UP = 1;
    localparam int M_DN = 2;
    localparam int M_LF = 4;
    localparam int M_RT = 8;
    localparam int M_OK = 16;

    typedef struct {
        int x;
        int y;
        int gap;
    } mv_t;

    logic       clk_in = 1'b0;
    logic       sys_rst = 1'b1;
    logic [4:0] btn = '0;
    logic       key_ready = 1'b0;
    logic [3:0] cursor_x;
    logic [3:0] cursor_y;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_ovf;

    cursor_ctrl #(
        .DEBOUNCE_CYC(4),
        .REPEAT_DLY  (20),
        .REPEAT_PER  (8)
    ) dut (
        .clk_in   (clk_in),
        .sys_rst  (sys_rst),
        .btn_up   (btn[0]),
        .btn_down (btn[1]),
        .btn_left (btn[2]),
        .btn_right(btn[3]),
        .btn_ok   (btn[4]),
        .cursor_x (cursor_x),
        .cursor_y (cursor_y),
        .key_valid(key_valid),
        .key_code (key_code),
        .key_ready(key_ready),
        .key_ovf  (key_ovf)
    );

    always #5 clk_in = ~clk_in;

    int  n_chk  = 0;
    int  n_pass = 0;
    int  cyc    = 0;
    int  t_mark = 0;
    bit  mon_en = 0;
    int  mx = 0;
    int  my = 0;
    mv_t q_cur[$];
    int  q_key[$];
    int  q_ovf[$];

    always @(posedge clk_in) cyc = cyc + 1;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk = n_chk + 1;
        if (got == exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic int key_exp(input int x, input int y);
        if (y < 3) return y * 3 + x + 1;
        if (x == 0) return 10;
        if (x == 1) return 0;
        return 11;
    endfunction

    function automatic void push_mv(input int gap);
        mv_t e;
        e.x = mx;
        e.y = my;
        e.gap = gap;
        q_cur.push_back(e);
    endfunction

    task automatic tap(input logic [4:0] m, input int hold);
        @(posedge clk_in);
        #1;
        btn = m;
        t_mark = cyc;
        repeat (hold) @(posedge clk_in);
        #1;
        btn = '0;
        repeat (12) @(posedge clk_in);
    endtask

    // Monitor: every cursor change, key load and overflow pulse
    // consumes one scoreboard entry.
    int  px = 0;
    int  py = 0;
    bit  pv = 0;
    bit  pacc = 0;
    always @(negedge clk_in) begin
        mv_t e;
        int  k;
        if (mon_en) begin
            if (int'(cursor_x) != px || int'(cursor_y) != py) begin
                if (q_cur.size() == 0) begin
                    chk("cur_unexpected", 0, 1);
                end else begin
                    e = q_cur.pop_front();
                    chk("cur_x", int'(cursor_x), e.x);
                    chk("cur_y", int'(cursor_y), e.y);
                    if (e.gap >= 0) chk("cur_gap", cyc - t_mark, e.gap);
                end
                t_mark = cyc;
            end
            if (key_valid && (!pv || pacc)) begin
                if (q_key.size() == 0) begin
                    chk("key_unexpected", 0, 1);
                end else begin
                    k = q_key.pop_front();
                    chk("key_code", int'(key_code), k);
                end
            end
            if (key_ovf) begin
                if (q_ovf.size() == 0) begin
                    chk("ovf_unexpected", 0, 1);
                end else begin
                    k = q_ovf.pop_front();
                    chk("ovf_code", int'(key_code), k);
                    chk("ovf_valid", int'(key_valid), 1);
                end
            end
        end
        px = int'(cursor_x);
        py = int'(cursor_y);
        pv = key_valid;
        pacc = key_valid && key_ready;
    end

    int hold_gap[6] = '{5, 20, 8, 8, 8, 8};

    initial begin
        repeat (3) @(posedge clk_in);
        #1 sys_rst = 1'b0;
        @(negedge clk_in);
        chk("rst_x", int'(cursor_x), 0);
        chk("rst_y", int'(cursor_y), 0);
        chk("rst_valid", int'(key_valid), 0);
        chk("rst_code", int'(key_code), 0);
        chk("rst_ovf", int'(key_ovf), 0);
        mon_en = 1;

        // 3-cycle glitch must not move; the real press moves once
        @(posedge clk_in);
        #1 btn = 5'(M_RT);
        repeat (3) @(posedge clk_in);
        #1 btn = '0;
        repeat (6) @(posedge clk_in);
        mx = 1; push_mv(5); tap(5'(M_RT), 10);

        // wrap cases
        mx = 0; push_mv(5); tap(5'(M_LF), 10);
        my = 3; push_mv(5); tap(5'(M_UP), 10);
        mx = 1; push_mv(5); tap(5'(M_RT), 10);
        mx = 2; push_mv(5); tap(5'(M_RT), 10);
        mx = 0; push_mv(5); tap(5'(M_RT), 10);
        my = 0; push_mv(5); tap(5'(M_DN), 10);

        // auto-repeat on a 60-cycle hold
        for (int i = 0; i < 6; i++) begin
            my = (my + 1) % 4;
            push_mv(hold_gap[i]);
        end
        tap(5'(M_DN), 60);

        // pending key, overflow, moves while pending
        mx = 1; push_mv(5); tap(5'(M_RT), 10);
        my = 3; push_mv(5); tap(5'(M_DN), 10);
        key_ready = 1'b0;
        q_key.push_back(key_exp(mx, my));
        tap(5'(M_OK), 10);
        q_ovf.push_back(key_exp(1, 3));
        tap(5'(M_OK), 10);
        mx = 0; push_mv(5); tap(5'(M_LF), 10);
        chk("pend_valid", int'(key_valid), 1);
        chk("pend_code", int'(key_code), 0);
        @(posedge clk_in);
        #1 key_ready = 1'b1;
        @(posedge clk_in);
        #1 chk("acc_valid", int'(key_valid), 0);

        // OK and LEFT together: key for old spot, no move
        q_key.push_back(key_exp(mx, my));
        tap(5'(M_OK | M_LF), 10);
        chk("okl_x", int'(cursor_x), 0);
        chk("okl_y", int'(cursor_y), 3);

        // reset during HOLD with a key pending
        my = 2; push_mv(5); tap(5'(M_UP), 10);
        mx = 1; push_mv(5); tap(5'(M_RT), 10);
        key_ready = 1'b0;
        q_key.push_back(key_exp(mx, my));
        tap(5'(M_OK), 10);
        my = 3; push_mv(5);
        @(posedge clk_in);
        #1 btn = 5'(M_DN);
        t_mark = cyc;
        repeat (10) @(posedge clk_in);
        chk("hold_valid", int'(key_valid), 1);
        mx = 0; my = 0; push_mv(-1);
        #1 sys_rst = 1'b1;
        #1;
        chk("arst_x", int'(cursor_x), 0);
        chk("arst_y", int'(cursor_y), 0);
        chk("arst_valid", int'(key_valid), 0);
        chk("arst_code", int'(key_code), 0);
        chk("arst_ovf", int'(key_ovf), 0);
        repeat (3) @(posedge clk_in);
        my = 1; push_mv(5);
        #1 sys_rst = 1'b0;
        t_mark = cyc;
        repeat (12) @(posedge clk_in);
        #1 btn = '0;
        repeat (40) @(posedge clk_in);

        @(negedge clk_in);
        chk("end_cur_q", q_cur.size(), 0);
        chk("end_key_q", q_key.size(), 0);
        chk("end_ovf_q", q_ovf.size(), 0);
        chk("end_x", int'(cursor_x), mx);
        chk("end_y", int'(cursor_y), my);
        chk("end_valid", int'(key_valid), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
